// File: rtl/seq_array_multiplier.sv
// Iterative shift-add multiplier: one partial product per clock, unsigned or
// two's-complement operands, valid/ready on both sides with a held result.
module seq_array_multiplier #(
  parameter int unsigned WIDTH = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned AW = PW + 1;
  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [AW-1:0]    mcand_q;
  logic [AW-1:0]    acc_q;
  logic [AW-1:0]    acc_d;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] mag1_d;
  logic [WIDTH-1:0] mag2_d;
  logic [CW-1:0]    cnt_q;
  logic             neg_q;
  logic             neg_d;
  logic [PW-1:0]    product_q;
  logic [PW-1:0]    product_d;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;

  // Magnitudes fit in WIDTH unsigned bits, so -2^(WIDTH-1) maps to 2^(WIDTH-1).
  always_comb begin
    mag1_d    = (signed_mode && in1[WIDTH-1]) ? -in1 : in1;
    mag2_d    = (signed_mode && in2[WIDTH-1]) ? -in2 : in2;
    neg_d     = signed_mode && (in1[WIDTH-1] ^ in2[WIDTH-1]);
    acc_d     = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    product_d = neg_q ? PW'(-acc_q) : PW'(acc_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mcand_q     <= '0;
      acc_q       <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
      neg_q       <= 1'b0;
      product_q   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            mcand_q    <= AW'(mag1_d);
            mplier_q   <= mag2_d;
            neg_q      <= neg_d;
            acc_q      <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= RUN;
          end
        end
        RUN: begin
          // WIDTH accumulate steps, then one step that applies the sign.
          if (cnt_q == LAST) begin
            product_q   <= product_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign product   = product_q;
  assign busy      = busy_q;

endmodule
